// File: rtl/exec_sequencer.sv
// Execute stage for the 8-bit core. Accepts one decoded instruction at a time
// and sequences it through operand read, ALU or iterative multiply, and
// write-back on the GPR ports. Produces Z/N/C flags and a completion pulse.
//
// Handshake: an instruction is accepted at a rising edge where
// instr_valid=1 and instr_ready=1. instr_ready is high only in IDLE, and
// instr_valid is ignored in every other state, so a held instr_valid
// yields exactly one acceptance per trip through IDLE.
module exec_sequencer #(
  parameter int DATA_W  = 8,
  parameter int REG_AW  = 3,
  parameter int MUL_CYC = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        opcode,
  input  logic [REG_AW-1:0] rs_a,
  input  logic [REG_AW-1:0] rs_b,
  input  logic [REG_AW-1:0] rd,
  input  logic [DATA_W-1:0] imm,
  output logic              gpr_read_en,
  output logic              gpr_write_en,
  output logic [REG_AW-1:0] gpr_a_num,
  output logic [REG_AW-1:0] gpr_b_num,
  output logic [REG_AW-1:0] gpr_c_num,
  output logic [DATA_W-1:0] gpr_c_data,
  input  logic [DATA_W-1:0] gpr_a_data,
  input  logic [DATA_W-1:0] gpr_b_data,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c,
  output logic              done,
  output logic [2:0]        dbg_state
);

  localparam int CNT_W = $clog2(MUL_CYC + 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MOV = 4'd8;
  localparam logic [3:0] OP_LDI = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;
  localparam logic [3:0] OP_NOP = 4'd12;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_EXEC  = 3'd2,
    S_MUL   = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [3:0]          op_q, op_d;
  logic [REG_AW-1:0]   rs_a_q, rs_a_d;
  logic [REG_AW-1:0]   rs_b_q, rs_b_d;
  logic [REG_AW-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                z_q, z_d;
  logic                n_q, n_d;
  logic                c_q, c_d;
  logic [2*DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [2*DATA_W-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [DATA_W:0]     sum_w;
  logic [DATA_W:0]     diff_w;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c;
  logic                alu_upd;
  logic [2*DATA_W-1:0] prod_next;
  logic                is_nop;
  logic                mul_last;

  assign sum_w     = {1'b0, gpr_a_data} + {1'b0, gpr_b_data};
  assign diff_w    = {1'b0, gpr_a_data} - {1'b0, gpr_b_data};
  assign prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign is_nop    = (op_q >= OP_NOP);
  assign mul_last  = (cnt_q == CNT_W'(MUL_CYC - 1));

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state sequencing: read, execute, optional multiply, write-back.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (instr_valid) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC: begin
        if (op_q == OP_MUL)                state_d = S_MUL;
        else if (op_q == OP_CMP || is_nop) state_d = S_IDLE;
        else                               state_d = S_WRITE;
      end
      S_MUL:   if (mul_last) state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from state and latched fields.
  always_comb begin
    instr_ready  = (state_q == S_IDLE);
    gpr_read_en  = (state_q == S_READ);
    gpr_a_num    = (state_q == S_READ) ? rs_a_q : '0;
    gpr_b_num    = (state_q == S_READ) ? rs_b_q : '0;
    gpr_write_en = (state_q == S_WRITE);
    gpr_c_num    = (state_q == S_WRITE) ? rd_q : '0;
    gpr_c_data   = (state_q == S_WRITE) ? result_q : '0;
    done         = (state_q == S_WRITE) ||
                   ((state_q == S_EXEC) && ((op_q == OP_CMP) || is_nop));
    flag_z       = z_q;
    flag_n       = n_q;
    flag_c       = c_q;
    dbg_state    = state_q;
  end

  // Single-cycle ALU on the operands returned by the registered GPR read.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_upd = 1'b1;
    case (op_q)
      OP_ADD: begin alu_res = sum_w[DATA_W-1:0];  alu_c = sum_w[DATA_W];  end
      OP_SUB,
      OP_CMP: begin alu_res = diff_w[DATA_W-1:0]; alu_c = diff_w[DATA_W]; end
      OP_AND: alu_res = gpr_a_data & gpr_b_data;
      OP_OR:  alu_res = gpr_a_data | gpr_b_data;
      OP_XOR: alu_res = gpr_a_data ^ gpr_b_data;
      OP_NOT: alu_res = ~gpr_a_data;
      OP_SHL: begin
        alu_res = {gpr_a_data[DATA_W-2:0], 1'b0};
        alu_c   = gpr_a_data[DATA_W-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, gpr_a_data[DATA_W-1:1]};
        alu_c   = gpr_a_data[0];
      end
      OP_MOV: begin alu_res = gpr_a_data; alu_upd = 1'b0; end
      OP_LDI: begin alu_res = imm_q;      alu_upd = 1'b0; end
      default: alu_upd = 1'b0;
    endcase
  end

  // Datapath next values: field capture, ALU result/flags, multiplier steps.
  always_comb begin
    op_d     = op_q;
    rs_a_d   = rs_a_q;
    rs_b_d   = rs_b_q;
    rd_d     = rd_q;
    imm_d    = imm_q;
    result_d = result_q;
    z_d      = z_q;
    n_d      = n_q;
    c_d      = c_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          op_d   = opcode;
          rs_a_d = rs_a;
          rs_b_d = rs_b;
          rd_d   = rd;
          imm_d  = imm;
        end
      end
      S_EXEC: begin
        if (op_q == OP_MUL) begin
          mcand_d  = {{DATA_W{1'b0}}, gpr_a_data};
          mplier_d = gpr_b_data;
          prod_d   = '0;
          cnt_d    = '0;
        end else begin
          result_d = alu_res;
          if (alu_upd) begin
            z_d = (alu_res == '0);
            n_d = alu_res[DATA_W-1];
            c_d = alu_c;
          end
        end
      end
      S_MUL: begin
        prod_d   = prod_next;
        mcand_d  = {mcand_q[2*DATA_W-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[DATA_W-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (mul_last) begin
          result_d = prod_next[DATA_W-1:0];
          z_d      = (prod_next[DATA_W-1:0] == '0);
          n_d      = prod_next[DATA_W-1];
          c_d      = |prod_next[2*DATA_W-1:DATA_W];
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; everything clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      rs_a_q   <= '0;
      rs_b_q   <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      result_q <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      op_q     <= op_d;
      rs_a_q   <= rs_a_d;
      rs_b_q   <= rs_b_d;
      rd_q     <= rd_d;
      imm_q    <= imm_d;
      result_q <= result_d;
      z_q      <= z_d;
      n_q      <= n_d;
      c_q      <= c_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: behavioural GPR file, in-order reference model,
// expected-response queue checked by a monitor on every done pulse.
module tb_exec_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [3:0] opcode = '0;
  logic [2:0] rs_a = '0, rs_b = '0, rd = '0;
  logic [7:0] imm = '0;
  logic       gpr_read_en, gpr_write_en;
  logic [2:0] gpr_a_num, gpr_b_num, gpr_c_num;
  logic [7:0] gpr_c_data;
  logic [7:0] gpr_a_data = '0, gpr_b_data = '0;
  logic       flag_z, flag_n, flag_c, done;
  logic [2:0] dbg_state;

  exec_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .rs_a(rs_a), .rs_b(rs_b), .rd(rd), .imm(imm),
    .gpr_read_en(gpr_read_en), .gpr_write_en(gpr_write_en),
    .gpr_a_num(gpr_a_num), .gpr_b_num(gpr_b_num), .gpr_c_num(gpr_c_num),
    .gpr_c_data(gpr_c_data), .gpr_a_data(gpr_a_data), .gpr_b_data(gpr_b_data),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .done(done),
    .dbg_state(dbg_state)
  );

  // clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // GPR file: registered reads, write on write_en; not affected by reset
  logic [7:0] gpr_mem [8] = '{default: 8'd0};
  always @(posedge clk) begin
    if (gpr_read_en) begin
      gpr_a_data <= gpr_mem[gpr_a_num];
      gpr_b_data <= gpr_mem[gpr_b_num];
    end
    if (gpr_write_en) gpr_mem[gpr_c_num] <= gpr_c_data;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model state: register contents and flags as the spec defines them
  int ref_gpr [8] = '{default: 0};
  bit ref_z = 0, ref_n = 0, ref_c = 0;

  // entry: [18]=write, [17:15]=rd, [14:7]=data, [6]=z, [5]=n, [4]=c, [3:0]=latency
  logic [18:0] exp_q[$];
  int          acc_q[$];

  function automatic logic [18:0] ref_step(input int op, input int a, input int b,
                                           input int d, input int im);
    int av = ref_gpr[a];
    int bv = ref_gpr[b];
    int r = 0;
    int p;
    int lat;
    bit wr = 1, upd = 1, c = 0;
    case (op)
      0:  begin r = av + bv; c = (r > 255); end
      1, 10: begin r = (av - bv + 256) % 256; c = (av < bv); end
      2:  r = av & bv;
      3:  r = av | bv;
      4:  r = av ^ bv;
      5:  r = 255 - av;
      6:  begin r = av * 2; c = (av >= 128); end
      7:  begin r = av / 2; c = (av % 2 == 1); end
      8:  begin r = av; upd = 0; end
      9:  begin r = im; upd = 0; end
      11: begin p = av * bv; r = p % 256; c = (p > 255); end
      default: begin wr = 0; upd = 0; end
    endcase
    if (op == 10) wr = 0;
    r = r % 256;
    if (upd) begin
      ref_z = (r == 0);
      ref_n = (r >= 128);
      ref_c = c;
    end
    if (wr) ref_gpr[d] = r;
    lat = (op == 11) ? 11 : (wr ? 3 : 2);
    return {wr, 3'(d), (wr ? 8'(r) : 8'd0), ref_z, ref_n, ref_c, 4'(lat)};
  endfunction

  // driver: present one instruction, wait for acceptance, record expectation
  task automatic issue(input int op, input int a, input int b, input int d,
                       input int im, input bit hold, input bit expect_it);
    int  guard = 0;
    bit  accepted = 0;
    int  acc;
    @(negedge clk);
    opcode = 4'(op); rs_a = 3'(a); rs_b = 3'(b); rd = 3'(d); imm = 8'(im);
    instr_valid = 1'b1;
    while (!accepted && guard < 200) begin
      if (instr_ready) begin
        acc = cyc + 1;
        @(posedge clk);
        accepted = 1;
      end else begin
        @(negedge clk);
        guard++;
      end
    end
    if (!accepted) begin
      chk("accept_timeout", 32'(instr_ready), 32'd1);
    end else if (expect_it) begin
      exp_q.push_back(ref_step(op, a, b, d, im));
      acc_q.push_back(acc);
    end
    #1;
    if (!hold) instr_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // monitor: per-cycle port rules, then compare each done pulse with the queue head
  bit         flag_pending = 0;
  logic [2:0] flag_exp = '0;
  always @(negedge clk) begin
    logic [18:0] e;
    int          a;
    chk("rd_wr_exclusive", 32'(gpr_read_en & gpr_write_en), 32'd0);
    if (!gpr_write_en) begin
      chk("c_num_idle_zero", 32'(gpr_c_num), 32'd0);
      chk("c_data_idle_zero", 32'(gpr_c_data), 32'd0);
    end
    if (flag_pending) begin
      chk("flags_zns", 32'({flag_z, flag_n, flag_c}), 32'(flag_exp));
      flag_pending = 0;
    end
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        chk("latency", 32'(cyc - a + 1), 32'(e[3:0]));
        chk("write_en", 32'(gpr_write_en), 32'(e[18]));
        if (e[18]) begin
          chk("wb_rd", 32'(gpr_c_num), 32'(e[17:15]));
          chk("wb_data", 32'(gpr_c_data), 32'(e[14:7]));
        end
        flag_exp = e[6:4];
        flag_pending = 1;
      end
    end else if (gpr_write_en) begin
      chk("write_without_done", 32'(gpr_write_en), 32'd0);
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_read_en"}, 32'(gpr_read_en), 32'd0);
    chk({tag, "_write_en"}, 32'(gpr_write_en), 32'd0);
    chk({tag, "_flags"}, 32'({flag_z, flag_n, flag_c}), 32'd0);
    chk({tag, "_ready"}, 32'(instr_ready), 32'd1);
    chk({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  initial begin
    // reset
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // 1: loads and ADD with carry
    issue(9, 0, 0, 1, 200, 0, 1);
    issue(9, 0, 0, 2, 100, 0, 1);
    issue(0, 1, 2, 3, 0, 0, 1);
    drain();
    chk("t1_r3", 32'(gpr_mem[3]), 32'd44);

    // 2: SUB with borrow, CMP of equal values
    issue(1, 2, 1, 4, 0, 0, 1);
    issue(10, 1, 1, 0, 0, 0, 1);
    drain();
    chk("t2_r4", 32'(gpr_mem[4]), 32'd156);
    chk("t2_cmp_flags", 32'({flag_z, flag_c}), 32'b10);

    // 3: multiplies, second one with rd aliasing rs_a
    issue(9, 0, 0, 6, 15, 0, 1);
    issue(9, 0, 0, 7, 17, 0, 1);
    issue(11, 6, 7, 5, 0, 0, 1);
    issue(9, 0, 0, 6, 16, 0, 1);
    issue(9, 0, 0, 7, 16, 0, 1);
    issue(11, 6, 7, 6, 0, 0, 1);
    drain();
    chk("t3_r5", 32'(gpr_mem[5]), 32'd255);
    chk("t3_r6", 32'(gpr_mem[6]), 32'd0);
    chk("t3_mul_flags", 32'({flag_z, flag_c}), 32'b11);

    // 4: instr_valid held high across three distinct ops
    issue(0, 1, 2, 3, 0, 1, 1);
    issue(4, 1, 2, 4, 0, 1, 1);
    issue(6, 1, 1, 0, 0, 0, 1);
    drain();

    // 5: reset during the fifth MUL cycle; rd must keep its value
    issue(11, 1, 2, 3, 0, 0, 0);
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    ref_z = 0; ref_n = 0; ref_c = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("t5_rd_kept", 32'(gpr_mem[3]), 32'(ref_gpr[3]));
    issue(0, 1, 2, 2, 0, 0, 1);
    drain();

    // 6: ADD wraps to zero with carry, then NOP leaves flags alone
    issue(9, 0, 0, 1, 128, 0, 1);
    issue(0, 1, 1, 1, 0, 0, 1);
    drain();
    chk("t6_r1", 32'(gpr_mem[1]), 32'd0);
    chk("t6_flags", 32'({flag_z, flag_c}), 32'b11);
    issue(13, 2, 3, 4, 0, 0, 1);
    drain();

    // random instruction stream
    for (int i = 0; i < 80; i++) begin
      bit h;
      h = ($urandom_range(0, 3) == 0);
      issue($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 255), h, 1);
      if (!h) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    instr_valid = 1'b0;
    drain();

    for (int r = 0; r < 8; r++) chk($sformatf("final_r%0d", r), 32'(gpr_mem[r]), 32'(ref_gpr[r]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
